// File: rtl/sdram_pkg.sv
// Shared constants and state encoding for the SDRAM command arbiter.
// Command word layout: {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0]}.
package sdram_pkg;

   localparam int CMD_W  = 18;
   localparam int WDOG_W = 11;

   localparam logic [CMD_W-1:0] NOP_CMD = 18'h1c000;
   localparam logic [CMD_W-1:0] REF_CMD = 18'h04000;
   // Precharge-all: A10 high selects every bank.
   localparam logic [CMD_W-1:0] PRE_CMD = 18'h08400;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// Requester/pin-side bundle of the SDRAM arbiter. master = requesters and
// pin consumer, slave = the arbiter.
interface sdram_arbit_if;
   import sdram_pkg::*;

   // Request/grant: *_req is a level held until *_en rises; *_en stays high
   // for the whole grant; *_end is a one-cycle pulse that closes the grant.
   logic [CMD_W-1:0] ini_cmd;
   logic             ini_end;
   logic             ref_req;
   logic [CMD_W-1:0] ref_cmd;
   logic             ref_end;
   logic             wr_req;
   logic [CMD_W-1:0] wr_cmd;
   logic             wr_end;
   logic             rd_req;
   logic [CMD_W-1:0] rd_cmd;
   logic             rd_end;
   logic             ref_en;
   logic             wr_en;
   logic             rd_en;
   logic [CMD_W-1:0] sdram_cmd;
   logic [2:0]       arb_state;
   logic             arb_err;

   modport master (
      output ini_cmd, ini_end,
      output ref_req, ref_cmd, ref_end,
      output wr_req, wr_cmd, wr_end,
      output rd_req, rd_cmd, rd_end,
      input  ref_en, wr_en, rd_en, sdram_cmd, arb_state, arb_err
   );

   modport slave (
      input  ini_cmd, ini_end,
      input  ref_req, ref_cmd, ref_end,
      input  wr_req, wr_cmd, wr_end,
      input  rd_req, rd_cmd, rd_end,
      output ref_en, wr_en, rd_en, sdram_cmd, arb_state, arb_err
   );

endinterface

// File: rtl/sdram_arb_wdog.sv
// Grant watchdog: saturating hold-time counter, expires on the cycle that
// would complete grant_to cycles in the current grant state.
module sdram_arb_wdog
   import sdram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              cnt_en,
   input  logic [WDOG_W-1:0] grant_to,
   output logic              expire
);

   localparam logic [WDOG_W-1:0] ONE = WDOG_W'(1);

   logic [WDOG_W-1:0] cnt;
   logic [WDOG_W-1:0] cnt_eff;

   // clr marks the first cycle of a new state, so the count restarts at once.
   assign cnt_eff = clr ? '0 : cnt;
   assign expire  = cnt_en && (cnt_eff == (grant_to - ONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (!cnt_en) begin
         cnt <= '0;
      end else if (cnt_eff != '1) begin
         cnt <= cnt_eff + ONE;
      end else begin
         cnt <= cnt_eff;
      end
   end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init, refresh, write and read sources share the pins.
// Define SDRAM_ARB_RR_EN to alternate write/read when both are pending.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int GRANT_TO = 1023
)(
   input logic          clk,
   input logic          rst,
   sdram_arbit_if.slave bus
);

   arb_state_t state;
   logic       st_chg;
   logic       grant_active;
   logic       cur_end;
   logic       pick_wr;
   logic       wd_expire;

`ifdef SDRAM_ARB_RR_EN
   logic last_wr;
   assign pick_wr = bus.wr_req && (!bus.rd_req || !last_wr);
`else
   assign pick_wr = bus.wr_req;
`endif

   assign grant_active = (state == AREF) || (state == WRITE) || (state == READ);

   // Only the end pulse of the granted requester counts.
   always_comb begin
      cur_end = 1'b0;
      case (state)
         AREF:    cur_end = bus.ref_end;
         WRITE:   cur_end = bus.wr_end;
         READ:    cur_end = bus.rd_end;
         default: cur_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= INIT;
         st_chg        <= 1'b0;
         bus.arb_err   <= 1'b0;
         bus.sdram_cmd <= NOP_CMD;
`ifdef SDRAM_ARB_RR_EN
         last_wr       <= 1'b0;
`endif
      end else begin
         st_chg      <= 1'b0;
         bus.arb_err <= 1'b0;
         case (state)
            INIT: begin
               if (bus.ini_end) begin
                  state  <= IDLE;
                  st_chg <= 1'b1;
               end
            end
            IDLE: begin
               if (bus.ref_req) begin
                  state  <= AREF;
                  st_chg <= 1'b1;
               end else if (pick_wr) begin
                  state  <= WRITE;
                  st_chg <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                  last_wr <= 1'b1;
`endif
               end else if (bus.rd_req) begin
                  state  <= READ;
                  st_chg <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
                  last_wr <= 1'b0;
`endif
               end
            end
            AREF, WRITE, READ: begin
               // A normal end on the expiry cycle is not an error.
               if (cur_end || wd_expire) begin
                  state       <= IDLE;
                  st_chg      <= 1'b1;
                  bus.arb_err <= !cur_end;
               end
            end
            default: begin
               state  <= INIT;
               st_chg <= 1'b1;
            end
         endcase

         case (state)
            INIT:    bus.sdram_cmd <= bus.ini_cmd;
            AREF:    bus.sdram_cmd <= bus.ref_cmd;
            WRITE:   bus.sdram_cmd <= bus.wr_cmd;
            READ:    bus.sdram_cmd <= bus.rd_cmd;
            default: bus.sdram_cmd <= NOP_CMD;
         endcase
      end
   end

   assign bus.arb_state = state;
   assign bus.ref_en    = (state == AREF);
   assign bus.wr_en     = (state == WRITE);
   assign bus.rd_en     = (state == READ);

   sdram_arb_wdog u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (st_chg),
      .cnt_en   (grant_active),
      .grant_to (WDOG_W'(GRANT_TO)),
      .expire   (wd_expire)
   );

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with a 20-cycle grant watchdog.
module tb_sdram_arbit;
   import sdram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sdram_arbit_if bus ();

   sdram_arbit #(.GRANT_TO(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ini_cmd = '0; bus.ini_end = 1'b0;
      bus.ref_req = 1'b0; bus.ref_cmd = REF_CMD; bus.ref_end = 1'b0;
      bus.wr_req  = 1'b0; bus.wr_cmd  = '0;      bus.wr_end  = 1'b0;
      bus.rd_req  = 1'b0; bus.rd_cmd  = '0;      bus.rd_end  = 1'b0;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!(bus.ref_en || bus.wr_en || bus.rd_en) && n < 10) begin
         tick();
         n++;
      end
      check(tag, (n < 10), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      check("rst_state", bus.arb_state, 0);
      check("rst_cmd", bus.sdram_cmd, 18'h1c000);
      check("rst_en", {bus.ref_en, bus.wr_en, bus.rd_en}, 0);
      check("rst_err", bus.arb_err, 0);

      // Reset still dominates the command register.
      bus.ini_cmd = 18'h12345;
      tick();
      check("rst_cmd_hold", bus.sdram_cmd, 18'h1c000);
      rst = 1'b0;
      tick();
      check("init_cmd0", bus.sdram_cmd, 18'h12345);
      check("init_state", bus.arb_state, 0);

      // Requests are ignored in INIT.
      bus.ini_cmd = 18'h0abcd;
      bus.wr_req  = 1'b1;
      bus.ref_req = 1'b1;
      tick();
      check("init_cmd1", bus.sdram_cmd, 18'h0abcd);
      check("init_ignore", {bus.ref_en, bus.wr_en, bus.rd_en, bus.arb_state}, 0);
      bus.wr_req  = 1'b0;
      bus.ref_req = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("init_wait", bus.arb_state, 0);
      bus.ini_end = 1'b1;
      tick();
      check("init_exit", bus.arb_state, 1);
      check("init_last_cmd", bus.sdram_cmd, 18'h0abcd);
      bus.ini_cmd = 18'h3ffff;
      tick();
      check("idle_nop", bus.sdram_cmd, 18'h1c000);

      // Refresh beats write on the same edge.
      bus.ref_cmd = REF_CMD;
      bus.wr_cmd  = 18'h01234;
      bus.ref_req = 1'b1;
      bus.wr_req  = 1'b1;
      tick();
      check("ref_first_state", bus.arb_state, 2);
      check("ref_first_en", {bus.ref_en, bus.wr_en, bus.rd_en}, 3'b100);
      check("ref_first_cmd", bus.sdram_cmd, 18'h1c000);
      bus.ref_req = 1'b0;
      tick();
      check("ref_cmd_out", bus.sdram_cmd, 18'h04000);
      bus.ref_end = 1'b1;
      tick();
      bus.ref_end = 1'b0;
      check("ref_end_idle", bus.arb_state, 1);
      check("ref_end_en", bus.ref_en, 0);
      tick();
      check("wr_after_ref", {bus.ref_en, bus.wr_en, bus.rd_en, bus.arb_state}, {3'b010, 3'd3});
      check("wr_first_cmd", bus.sdram_cmd, 18'h1c000);
      bus.wr_req = 1'b0;
      tick();
      check("wr_cmd_out", bus.sdram_cmd, 18'h01234);

      // Refresh does not preempt a write; a stray rd_end is ignored.
      bus.ref_req = 1'b1;
      bus.rd_end  = 1'b1;
      tick();
      bus.rd_end = 1'b0;
      check("no_preempt", {bus.wr_en, bus.arb_state}, {1'b1, 3'd3});
      tick();
      tick();
      check("no_preempt2", bus.wr_en, 1);
      bus.wr_cmd = 18'h05555;
      bus.wr_end = 1'b1;
      tick();
      bus.wr_end = 1'b0;
      check("wr_end_idle", {bus.wr_en, bus.arb_state}, {1'b0, 3'd1});
      check("wr_last_cmd", bus.sdram_cmd, 18'h05555);
      bus.wr_cmd = 18'h3ffff;
      tick();
      check("aref_after_wr", bus.arb_state, 2);
      check("late_cmd_dropped", bus.sdram_cmd, 18'h1c000);
      bus.ref_req = 1'b0;
      bus.ref_end = 1'b1;
      tick();
      bus.ref_end = 1'b0;
      check("aref_done", bus.arb_state, 1);

      // Watchdog: write held with no end.
      bus.wr_req = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      check("wd_enter", bus.arb_state, 3);
      for (int i = 0; i < 19; i++) tick();
      check("wd_hold19", {bus.wr_en, bus.arb_err, bus.arb_state}, {1'b1, 1'b0, 3'd3});
      tick();
      check("wd_expire", {bus.wr_en, bus.arb_err, bus.arb_state}, {1'b0, 1'b1, 3'd1});
      tick();
      check("wd_err_pulse", bus.arb_err, 0);

      // End on the expiry cycle wins over the watchdog.
      bus.wr_req = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      for (int i = 0; i < 19; i++) tick();
      bus.wr_end = 1'b1;
      tick();
      bus.wr_end = 1'b0;
      check("wd_tie", {bus.arb_err, bus.arb_state}, {1'b0, 3'd1});

      // Reset in the middle of a read.
      bus.rd_cmd = 18'h2aaaa;
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      check("rd_grant", {bus.rd_en, bus.arb_state}, {1'b1, 3'd4});
      tick();
      check("rd_cmd_out", bus.sdram_cmd, 18'h2aaaa);
      rst = 1'b1;
      tick();
      check("rst_mid_state", bus.arb_state, 0);
      check("rst_mid_en", bus.rd_en, 0);
      check("rst_mid_cmd", bus.sdram_cmd, 18'h1c000);

      clear_inputs();
      tick();
      rst = 1'b0;
      bus.ini_end = 1'b1;
      tick();
      check("reinit_idle", bus.arb_state, 1);

      // Write and read held high through four bursts.
`ifdef SDRAM_ARB_RR_EN
      exp_q = '{3'd3, 3'd4, 3'd3, 3'd4};
`else
      exp_q = '{3'd3, 3'd3, 3'd3, 3'd3};
`endif
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      for (int b = 0; b < 4; b++) begin
         wait_grant($sformatf("burst%0d_grant", b));
         check($sformatf("burst%0d_order", b), bus.arb_state, exp_q.pop_front());
         if (bus.wr_en) bus.wr_end = 1'b1;
         else           bus.rd_end = 1'b1;
         tick();
         bus.wr_end = 1'b0;
         bus.rd_end = 1'b0;
         check($sformatf("burst%0d_idle", b), bus.arb_state, 1);
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
